// File: rtl/spawn_rng_pkg.sv
// spawn_rng_pkg: shared game encodings, LFSR constants and spawn FSM states
package spawn_rng_pkg;
  localparam logic [2:0] GS_TITLE = 3'd0;
  localparam logic [2:0] GS_READY = 3'd1;
  localparam logic [2:0] GS_PAUSE = 3'd2;
  localparam logic [2:0] GS_PLAY  = 3'd3;
  localparam logic [2:0] GS_OVER  = 3'd4;
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam logic [15:0] SEED_WHITEN = 16'hACE1;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_OFFER} spawn_state_e;
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction
  function automatic logic [1:0] lane_of(input logic [15:0] v);
    return v[15:14] == 2'd3 ? {1'b0, v[13]} : v[15:14];
  endfunction
endpackage

// File: rtl/spawn_rng_lfsr.sv
// galois_lfsr16: 16-bit Galois LFSR with synchronous load and step enable
module galois_lfsr16 import spawn_rng_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        step_i,
  output logic [15:0] state_o
);
  logic [15:0] state_q;
  // load wins over step; the register restarts from the whitening constant
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= SEED_WHITEN;
    else if (load_i) state_q <= load_val_i;
    else if (step_i) state_q <= lfsr_next(state_q);
  assign state_o = state_q;
endmodule

// File: rtl/spawn_rng.sv
// spawn_rng: expands relife seeds into an LFSR and offers spawn events at random gaps
module spawn_rng import spawn_rng_pkg::*; #(
  parameter int         MIN_GAP    = 16,
  parameter int         GAP_W      = 5,
  parameter logic [2:0] PLAY_STATE = GS_PLAY
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [1:0]  seed_1,
  input  logic [1:0]  seed_2,
  input  logic        relife,
  input  logic [2:0]  game_state,
  input  logic        rand_ready,
  output logic        rand_valid,
  output logic [1:0]  rand_lane,
  output logic [15:0] spawn_count,
  output logic [15:0] lfsr_state
);
  spawn_state_e state_q, state_d;
  logic        pend_q, pend_d, relife_q;
  logic [5:0]  gap_q, gap_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] count_q, count_d, seed_val, load_val;
  logic        fall, play, lfsr_load, lfsr_step;
  function automatic logic [5:0] gap_of(input logic [15:0] v);
    return 6'(MIN_GAP) + 6'(v[GAP_W-1:0]);
  endfunction
  galois_lfsr16 u_lfsr (
    .clk(frame_clk), .rst(Reset), .load_i(lfsr_load), .load_val_i(load_val),
    .step_i(lfsr_step), .state_o(lfsr_state)
  );
  // state, pending-load flag, relife edge detector, gap counter, lane and event count
  always_ff @(posedge frame_clk or posedge Reset)
    if (Reset) begin
      state_q  <= S_IDLE;
      pend_q   <= 1'b1;
      relife_q <= 1'b0;
      gap_q    <= '0;
      lane_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      relife_q <= relife;
      gap_q    <= gap_d;
      lane_q   <= lane_d;
      count_q  <= count_d;
    end
  // next state; relife (level or falling edge) overrides everything and drops any offer
  always_comb begin
    fall      = relife_q & ~relife;
    play      = game_state == PLAY_STATE;
    seed_val  = {4{seed_2, seed_1}} ^ SEED_WHITEN;
    load_val  = seed_val == '0 ? 16'h0001 : seed_val;
    state_d   = state_q;
    pend_d    = pend_q | fall;
    gap_d     = gap_q;
    lane_d    = lane_q;
    count_d   = count_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    if (relife | fall) state_d = S_IDLE;
    else
      case (state_q)
        S_IDLE:
          if (pend_q) state_d = S_LOAD;
          else if (play) begin
            state_d = S_WAIT;
            gap_d   = gap_of(lfsr_state);
          end
        S_LOAD: begin
          lfsr_load = 1'b1;
          pend_d    = 1'b0;
          count_d   = '0;
          state_d   = S_IDLE;
        end
        S_WAIT:
          if (play) begin
            if (gap_q == '0) begin
              state_d = S_OFFER;
              lane_d  = lane_of(lfsr_state);
            end else gap_d = gap_q - 6'd1;
          end
        default:
          if (rand_ready) begin
            lfsr_step = 1'b1;
            count_d   = count_q + 16'd1;
            state_d   = S_WAIT;
            gap_d     = gap_of(lfsr_next(lfsr_state));
          end
      endcase
  end
  assign rand_valid  = state_q == S_OFFER;
  assign rand_lane   = lane_q;
  assign spawn_count = count_q;
endmodule
